// File: rtl/hs_pkg.sv
// Shared definitions for the clocked ends of the self-timed handshake FIFO pipeline.
package hs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RTZ  = 2'd2
  } hs_state_t;

  localparam int HS_DATA_WIDTH = 3;
  localparam int HS_SYNC_MIN   = 2;
  localparam int HS_SYNC_MAX   = 4;

endpackage

// File: rtl/hs_sync.sv
// N-flop synchronizer bringing an asynchronous handshake line into the clk domain.
module hs_sync
  import hs_pkg::*;
#(
  parameter int STAGES = HS_SYNC_MIN
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/hs_stage_tx.sv
// Clocked ready/valid to 4-phase return-to-zero transmitter feeding the first
// self-timed stage of the handshake FIFO pipeline.
module hs_stage_tx
  import hs_pkg::*;
#(
  parameter int DATA_WIDTH     = HS_DATA_WIDTH,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  valid_out,
  input  logic                  ack_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  xfer_count,
  output logic                  timeout,
  output logic                  proto_err
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);

  hs_state_t             state, state_nxt;
  logic                  ack_s;
  logic                  valid_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic [CNT_WIDTH-1:0]  cnt_nxt;
  logic [WAIT_W-1:0]     wait_cnt, wait_nxt;
  logic                  timeout_nxt;
  logic                  proto_nxt;

  hs_sync #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk(clk),
    .rst(rst),
    .d  (ack_in),
    .q  (ack_s)
  );

  // A stale ack from the stage blocks acceptance so a new request never overlaps it.
  assign s_ready = !rst && (state == IDLE) && !ack_s;
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    valid_nxt   = valid_out;
    data_nxt    = data_out;
    cnt_nxt     = xfer_count;
    proto_nxt   = proto_err;
    wait_nxt    = wait_cnt;
    timeout_nxt = timeout;

    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        if (ack_s) begin
          proto_nxt = 1'b1;
        end else if (s_valid && s_ready) begin
          data_nxt  = s_data;
          valid_nxt = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        valid_nxt = 1'b1;
        if (ack_s) begin
          valid_nxt = 1'b0;
          cnt_nxt   = xfer_count + CNT_WIDTH'(1);
          state_nxt = RTZ;
        end
      end
      RTZ: begin
        valid_nxt = 1'b0;
        if (!ack_s) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase

    // The wait counter only flags a stuck stage; the FSM keeps waiting.
    if (state_nxt != state) begin
      wait_nxt = '0;
    end else if (state != IDLE) begin
      if (wait_cnt != WAIT_MAX) begin
        wait_nxt = wait_cnt + WAIT_W'(1);
      end
      if (wait_nxt == WAIT_MAX) begin
        timeout_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      valid_out  <= 1'b0;
      data_out   <= '0;
      xfer_count <= '0;
      wait_cnt   <= '0;
      timeout    <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      valid_out  <= valid_nxt;
      data_out   <= data_nxt;
      xfer_count <= cnt_nxt;
      wait_cnt   <= wait_nxt;
      timeout    <= timeout_nxt;
      proto_err  <= proto_nxt;
    end
  end

endmodule

// File: tb/tb_hs_stage_tx.sv
// Self-checking bench for hs_stage_tx with a behavioural model of the first pipeline stage.
module tb_hs_stage_tx;

  localparam int DW = 3;
  localparam int SS = 2;
  localparam int TO = 255;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          valid_out;
  logic          ack_in;
  logic [DW-1:0] data_out;
  logic          busy;
  logic [CW-1:0] xfer_count;
  logic          timeout;
  logic          proto_err;

  logic          stage_en;
  logic          ack_model;
  logic          ack_force;
  int            ack_delay = 2;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            exp_count = 0;
  logic [DW-1:0] rx_q[$];

  always #5 clk = ~clk;

  assign ack_in = stage_en ? ack_model : ack_force;

  hs_stage_tx #(
    .DATA_WIDTH(DW),
    .SYNC_STAGES(SS),
    .TIMEOUT_CYCLES(TO),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .valid_out(valid_out),
    .ack_in(ack_in),
    .data_out(data_out),
    .busy(busy),
    .xfer_count(xfer_count),
    .timeout(timeout),
    .proto_err(proto_err)
  );

  // Pipeline stage model: latches the word when it acks, then returns to zero.
  initial begin
    int dly;
    dly = 0;
    ack_model = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!stage_en) begin
        ack_model = 1'b0;
        dly = 0;
      end else if (valid_out && !ack_model) begin
        dly++;
        if (dly >= ack_delay) begin
          ack_model = 1'b1;
          rx_q.push_back(data_out);
          dly = 0;
        end
      end else if (!valid_out && ack_model) begin
        dly++;
        if (dly >= ack_delay) begin
          ack_model = 1'b0;
          dly = 0;
        end
      end else begin
        dly = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_word(input logic [DW-1:0] w, output bit ok);
    int n;
    n = 0;
    s_data = w;
    s_valid = 1'b1;
    while (!s_ready && n < 300) begin
      tick();
      n++;
    end
    ok = s_ready;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    while (busy && n < 600) begin
      tick();
      n++;
    end
    ok = !busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_valid = 1'b1;
    s_data = 3'd7;
    ack_force = 1'b1;
    stage_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (valid_out !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_ctrl: valid_out=%b s_ready=%b busy=%b, required 0 0 0", valid_out, s_ready, busy);
      end
      checks++;
      if (xfer_count !== '0 || data_out !== '0 || timeout !== 1'b0 || proto_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_regs: count=%0d data=%0d timeout=%b proto=%b, required all 0", xfer_count, data_out, timeout, proto_err);
      end
    end
    rst = 1'b0;
    s_valid = 1'b0;
    ack_force = 1'b0;
    for (int i = 0; i < SS + 1; i++) tick();
    checks++;
    if (s_ready !== 1'b1 || proto_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: s_ready=%b proto=%b busy=%b, required 1 0 0", s_ready, proto_err, busy);
    end
  endtask

  task automatic test_single();
    bit ok;
    bit stable;
    int last_low;
    int fall;
    rx_q.delete();
    stage_en = 1'b1;
    ack_delay = 2;
    send_word(3'd5, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL single_accept: s_ready never rose, required acceptance");
    end
    checks++;
    if (valid_out !== 1'b1 || data_out !== 3'd5) begin
      errors++;
      $display("[TB] FAIL single_request: valid_out=%b data_out=%0d, required 1 5", valid_out, data_out);
    end
    stable = 1'b1;
    last_low = cyc;
    fall = -1;
    for (int n = 0; n < 100 && fall < 0; n++) begin
      tick();
      if (valid_out) begin
        if (data_out !== 3'd5) stable = 1'b0;
        if (ack_in === 1'b0) last_low = cyc;
      end else begin
        fall = cyc;
      end
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("[TB] FAIL single_stable: data_out changed during request, required 5");
    end
    checks++;
    if (fall < 0 || fall - last_low != SS + 1) begin
      errors++;
      $display("[TB] FAIL single_fall_latency: got %0d cycles, required %0d", fall - last_low, SS + 1);
    end
    wait_idle(ok);
    exp_count++;
    checks++;
    if (!ok || xfer_count !== CW'(exp_count)) begin
      errors++;
      $display("[TB] FAIL single_count: idle=%b count=%0d, required 1 %0d", ok, xfer_count, exp_count);
    end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 3'd5 || s_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_delivery: received=%0d s_ready=%b, required 1 word of 5 and s_ready 1", rx_q.size(), s_ready);
    end
  endtask

  task automatic test_stream();
    logic [DW-1:0] words[4];
    bit ok;
    bit overlap;
    bit order_ok;
    bit accept;
    int idx;
    words[0] = 3'd1;
    words[1] = 3'd2;
    words[2] = 3'd3;
    words[3] = 3'd4;
    rx_q.delete();
    stage_en = 1'b1;
    ack_delay = 1;
    overlap = 1'b0;
    order_ok = 1'b1;
    idx = 0;
    s_data = words[0];
    s_valid = 1'b1;
    for (int n = 0; n < 400 && idx < 4; n++) begin
      if (s_ready && busy) overlap = 1'b1;
      accept = s_ready;
      tick();
      if (accept) begin
        if (busy !== 1'b1 || data_out !== words[idx]) order_ok = 1'b0;
        idx++;
        if (idx < 4) s_data = words[idx];
      end
    end
    s_valid = 1'b0;
    wait_idle(ok);
    exp_count += 4;
    checks++;
    if (idx != 4 || !order_ok) begin
      errors++;
      $display("[TB] FAIL stream_accept: accepted=%0d in_order=%b, required 4 1", idx, order_ok);
    end
    checks++;
    if (overlap) begin
      errors++;
      $display("[TB] FAIL stream_ready_busy: s_ready high while busy, required never");
    end
    checks++;
    if (rx_q.size() != 4 || rx_q[0] !== 3'd1 || rx_q[1] !== 3'd2 || rx_q[2] !== 3'd3 || rx_q[3] !== 3'd4) begin
      errors++;
      $display("[TB] FAIL stream_order: received %0d words, required 1,2,3,4", rx_q.size());
    end
    checks++;
    if (!ok || xfer_count !== CW'(exp_count)) begin
      errors++;
      $display("[TB] FAIL stream_count: count=%0d, required %0d", xfer_count, exp_count);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] sent[$];
    logic [DW-1:0] w;
    bit ok;
    bit all_ok;
    rx_q.delete();
    stage_en = 1'b1;
    all_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ack_delay = $urandom_range(1, 4);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      w = DW'($urandom);
      sent.push_back(w);
      send_word(w, ok);
      if (!ok) all_ok = 1'b0;
      checks++;
      if (valid_out !== 1'b1 || data_out !== w) begin
        errors++;
        $display("[TB] FAIL random_request: valid_out=%b data_out=%0d, required 1 %0d", valid_out, data_out, w);
      end
      wait_idle(ok);
      if (!ok) all_ok = 1'b0;
    end
    exp_count += 20;
    checks++;
    if (!all_ok || rx_q.size() != sent.size()) begin
      errors++;
      $display("[TB] FAIL random_flow: completed=%b received=%0d, required 1 %0d", all_ok, rx_q.size(), sent.size());
    end else begin
      for (int i = 0; i < sent.size(); i++) begin
        checks++;
        if (rx_q[i] !== sent[i]) begin
          errors++;
          $display("[TB] FAIL random_data[%0d]: got %0d, required %0d", i, rx_q[i], sent[i]);
        end
      end
    end
    checks++;
    if (xfer_count !== CW'(exp_count)) begin
      errors++;
      $display("[TB] FAIL random_count: count=%0d, required %0d", xfer_count, exp_count);
    end
  endtask

  task automatic test_spurious_ack();
    bit early;
    bit blocked;
    bit ok;
    int n;
    rx_q.delete();
    stage_en = 1'b0;
    ack_force = 1'b1;
    early = 1'b0;
    for (int k = 0; k < SS; k++) begin
      tick();
      if (proto_err !== 1'b0) early = 1'b1;
    end
    s_data = 3'd6;
    s_valid = 1'b1;
    tick();
    checks++;
    if (early || proto_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL spurious_latency: early=%b proto_err=%b, required 0 then 1 after %0d cycles", early, proto_err, SS + 1);
    end
    blocked = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (s_ready !== 1'b0 || busy !== 1'b0) blocked = 1'b0;
      tick();
    end
    checks++;
    if (!blocked) begin
      errors++;
      $display("[TB] FAIL spurious_block: word accepted while ack high, required none");
    end
    ack_force = 1'b0;
    n = 0;
    while (!s_ready && n < 20) begin
      tick();
      n++;
    end
    tick();
    s_valid = 1'b0;
    checks++;
    if (valid_out !== 1'b1 || data_out !== 3'd6) begin
      errors++;
      $display("[TB] FAIL spurious_resume: valid_out=%b data_out=%0d, required 1 6", valid_out, data_out);
    end
    stage_en = 1'b1;
    ack_delay = 1;
    wait_idle(ok);
    exp_count++;
    checks++;
    if (!ok || xfer_count !== CW'(exp_count) || proto_err !== 1'b1 || rx_q.size() != 1) begin
      errors++;
      $display("[TB] FAIL spurious_finish: count=%0d proto=%b received=%0d, required %0d 1 1", xfer_count, proto_err, rx_q.size(), exp_count);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int bad_c;
    int n;
    stage_en = 1'b0;
    ack_force = 1'b0;
    send_word(3'd3, ok);
    bad_c = -1;
    for (int c = 1; c <= TO + 3 && bad_c < 0; c++) begin
      tick();
      if (timeout !== (c >= TO) || valid_out !== 1'b1) bad_c = c;
    end
    checks++;
    if (!ok || bad_c >= 0) begin
      errors++;
      $display("[TB] FAIL timeout_edge: wrong at cycle %0d (timeout=%b valid_out=%b), required rise at cycle %0d", bad_c, timeout, valid_out, TO);
    end
    ack_force = 1'b1;
    n = 0;
    while (valid_out && n < 20) begin
      tick();
      n++;
    end
    ack_force = 1'b0;
    wait_idle(ok);
    exp_count++;
    checks++;
    if (!ok || timeout !== 1'b1 || xfer_count !== CW'(exp_count)) begin
      errors++;
      $display("[TB] FAIL timeout_recover: idle=%b timeout=%b count=%0d, required 1 1 %0d", ok, timeout, xfer_count, exp_count);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    stage_en = 1'b0;
    ack_force = 1'b0;
    send_word(3'd2, ok);
    tick();
    tick();
    checks++;
    if (!ok || valid_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_setup: valid_out=%b, required 1", valid_out);
    end
    rst = 1'b1;
    tick();
    exp_count = 0;
    checks++;
    if (valid_out !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0 || xfer_count !== CW'(exp_count)) begin
      errors++;
      $display("[TB] FAIL midreset_state: valid_out=%b busy=%b s_ready=%b count=%0d, required 0 0 0 0", valid_out, busy, s_ready, xfer_count);
    end
    checks++;
    if (timeout !== 1'b0 || proto_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_sticky: timeout=%b proto=%b, required 0 0", timeout, proto_err);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_ready: s_ready=%b, required 1", s_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_random();
    test_spurious_ack();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
